// File: rtl/bcd_to_binary_pkg.sv
// Shared constants for the BCD-to-binary converter: sizing defaults,
// nibble width and the legacy 3-bit FSM state encoding.
package bcd_to_binary_pkg;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned BIN_W_DEF  = 14;
  localparam int unsigned NIB_W      = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction cell: a BCD nibble >= 8 has 3 subtracted.
module bcd_digit_sub3
  import bcd_to_binary_pkg::*;
(
  input  logic [NIB_W-1:0] din,
  output logic [NIB_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= NIB_W'(8))
      dout = din - NIB_W'(3);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 4-digit packed BCD to 14-bit binary converter using the
// shift-right / subtract-3 (reverse double-dabble) algorithm.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [DIGITS*NIB_W-1:0] BCDIN,
  output logic [BIN_W-1:0]        BIN,
  output logic                    DONE,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int unsigned BCD_W    = DIGITS * NIB_W;
  localparam int unsigned SR_W     = BCD_W + BIN_W;
  localparam logic [3:0]  CNT_LAST = 4'(BIN_W);

  logic [2:0]       state;
  logic [SR_W-1:0]  sr;
  logic [3:0]       cnt;
  logic             invalid;
  logic [BCD_W-1:0] bcd_fix;
  logic             bcdin_bad;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_fix
    bcd_digit_sub3 u_sub3 (
      .din  (sr[BIN_W + g*NIB_W +: NIB_W]),
      .dout (bcd_fix[g*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    bcdin_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (BCDIN[i*NIB_W +: NIB_W] > NIB_W'(9))
        bcdin_bad = 1'b1;
  end

  // BUSY stays up for one IDLE cycle after the DONE pulse, so a held START
  // is only re-accepted on the cycle after BUSY drops (32-cycle cadence).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      invalid <= 1'b0;
      BIN     <= '0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (BUSY) begin
            BUSY <= 1'b0;
          end else if (START) begin
            BUSY  <= 1'b1;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          sr      <= {BCDIN, {BIN_W{1'b0}}};
          cnt     <= '0;
          invalid <= bcdin_bad;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sr    <= sr >> 1;
          cnt   <= cnt + 4'd1;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end else begin
            sr    <= {bcd_fix, sr[BIN_W-1:0]};
            state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          BIN   <= invalid ? '0 : sr[BIN_W-1:0];
          ERR   <= invalid;
          DONE  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed boundary cases plus
// random BCD words checked against a decimal-arithmetic reference.
module tb_bcd_to_binary;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] BCDIN;
  logic [13:0] BIN;
  logic        DONE;
  logic        BUSY;
  logic        ERR;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BCDIN (BCDIN),
    .BIN   (BIN),
    .DONE  (DONE),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Returns {err, value}; value is 0 when any digit is not decimal.
  function automatic logic [14:0] ref_conv(input logic [15:0] bcd);
    int unsigned v;
    int unsigned nib;
    logic        e;
    v = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      nib = (32'(bcd) >> (4*i)) & 32'd15;
      if (nib > 9) e = 1'b1;
      v = v * 10 + nib;
    end
    return e ? {1'b1, 14'd0} : {1'b0, 14'(v)};
  endfunction

  // One conversion starting now (edge 0 = next rising edge). sa/sb: extra
  // START pulses at those edges; rst_at: edge where RST is sampled low (0 = none).
  task automatic convert(input logic [15:0] bcd, input int sa, input int sb, input int rst_at);
    logic [14:0] exp;
    int          ndone;
    logic        aborted;
    exp     = ref_conv(bcd);
    ndone   = 0;
    aborted = 1'b0;
    BCDIN   = bcd;
    START   = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      @(posedge CLK); #1;
      START = (e + 1 == sa) || (e + 1 == sb);
      RST   = (e + 1 == rst_at) ? 1'b0 : 1'b1;
      if (e == 1) BCDIN = 16'($urandom);
      if (rst_at > 0 && e >= rst_at) aborted = 1'b1;
      if (DONE) ndone++;
      if (aborted) begin
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_bin", 32'(BIN), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
      end else begin
        check("busy", 32'(BUSY), 32'(e <= 30));
        check("done", 32'(DONE), 32'(e == 30));
        if (e == 30) begin
          check("bin", 32'(BIN), 32'(exp[13:0]));
          check("err", 32'(ERR), 32'(exp[14]));
        end
      end
    end
    check("done_count", 32'(ndone), aborted ? 32'd0 : 32'd1);
  endtask

  task automatic back_to_back();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    BCDIN = 16'h0001;
    START = 1'b1;
    for (int e = 0; e <= 66; e++) begin
      @(posedge CLK); #1;
      if (e == 1)  BCDIN = 16'h0010;
      if (e == 40) START = 1'b0;
      if (DONE) begin
        if (d1 < 0) begin
          d1 = e;
          check("b2b_bin1", 32'(BIN), 32'd1);
        end else begin
          d2 = e;
          check("b2b_bin2", 32'(BIN), 32'd10);
        end
      end
    end
    check("b2b_first", 32'(d1), 32'd30);
    check("b2b_gap", 32'(d2 - d1), 32'd32);
    check("b2b_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    RST   = 1'b0;
    START = 1'b0;
    BCDIN = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bin", 32'(BIN), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    convert(16'h0000, 0, 0, 0);
    convert(16'h9999, 0, 0, 0);
    convert(16'h0255, 0, 0, 0);
    convert(16'h1024, 0, 0, 0);
    convert(16'h12A4, 0, 0, 0);
    convert(16'h0042, 0, 0, 0);
    convert(16'h0777, 5, 20, 0);
    convert(16'h5000, 0, 0, 15);
    convert(16'h5000, 0, 0, 0);
    convert(16'hFFFF, 0, 0, 0);
    convert(16'h0008, 0, 0, 0);
    back_to_back();

    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 3) begin
        w = 16'($urandom);
      end else begin
        w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      convert(w, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential converter from 4-digit packed BCD (0000–9999) to a 14-bit unsigned binary value.
- Uses the reverse double-dabble (shift-right, subtract-3) algorithm, so it is the inverse of the existing binary-to-BCD converter.
- Sits between keypad/score-entry logic and arithmetic logic that needs binary operands.
- One conversion per START; reports invalid digits with an error flag.

Parameters:
- DIGITS, 4, number of BCD digits at the input. Fixed at 4 for this release; other values are not supported.
- BIN_W, 14, result width. Must equal ceil(log2(10^DIGITS)); also the number of shift iterations.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  synchronous, active-low reset (sampled on rising CLK; 0 = reset).
- START  input  1  begin conversion. Sampled only in IDLE.
- BCDIN  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- BIN  output  14  converted binary result. Registered; holds the last result.
- DONE  output  1  one-cycle pulse when BIN/ERR update.
- BUSY  output  1  high in every state except IDLE.
- ERR  output  1  last conversion had a nibble > 9. Held until the next DONE.

Behaviour:
- Reset (RST=0 at a rising edge):
  - State goes to IDLE.
  - BIN=0, DONE=0, ERR=0, BUSY=0.
  - Shift register and iteration counter are cleared.
  - Reset mid-conversion aborts it with no DONE pulse.
- Datapath:
  - 30-bit shift register SR = {bcd[15:0], bin[13:0]}.
  - 4-bit iteration counter CNT counts 0..14.
- States: IDLE, INIT, SHIFT, CHECK, DONE.
- IDLE: START=1 -> INIT; otherwise stay in IDLE.
- INIT:
  - SR <= {BCDIN, 14'b0}; CNT <= 0.
  - Latch invalid = (any BCDIN nibble > 9).
  - Next state SHIFT.
  - BCDIN is sampled at this edge (one cycle after START is sampled). The source holds BCDIN stable for 2 cycles from START.
- SHIFT: SR <= SR >> 1 (zero fill at MSB); CNT <= CNT+1; next state CHECK.
- CHECK:
  - If CNT != BIN_W: each of the 4 BCD nibbles in SR[29:14] that is >= 8 gets 3 subtracted, all nibbles in parallel from the same pre-edge value. Next state SHIFT.
  - If CNT == BIN_W: no correction; next state DONE.
- DONE:
  - BIN <= invalid ? 0 : SR[13:0].
  - ERR <= invalid.
  - DONE <= 1.
  - Next state IDLE.
- DONE is cleared to 0 at the following edge, so it is a single-cycle pulse.
- Latency:
  - The edge that samples START is edge 0.
  - BIN, ERR and the DONE pulse are visible after edge 2*BIN_W+2 = 30.
  - BUSY is high from edge 0 through edge 30 and low after edge 31 (back in IDLE).
- START while BUSY is ignored and not queued.
- START held high continuously gives back-to-back conversions, one every 32 cycles (IDLE visited 1 cycle).
- Nibble arithmetic is 4-bit modulo; correction never underflows, because a nibble >= 8 stays >= 5 after subtracting 3.
- Valid input range maps to 0x0000–0x270F. The upper BCD field is all-zero after the 14th shift for valid input.

Decomposition:
- Shared package holds:
  - State encoding constants (3-bit: IDLE=0, INIT=1, SHIFT=2, CHECK=3, DONE=4).
  - BIN_W/DIGITS defaults.
  - Nibble-width constant.
- One natural sub-module: bcd_digit_sub3, a combinational 4-bit "if >=8 then -3" cell instantiated DIGITS times in CHECK.
- FSM and shift register stay in the top module.

Test Plan:
- Reset then BCDIN=16'h0000, START pulse -> after edge 30: DONE=1 for one cycle, BIN=0, ERR=0; BUSY low after edge 31.
- BCDIN=16'h9999 -> BIN=14'h270F (9999), ERR=0. BCDIN=16'h0255 -> BIN=255. BCDIN=16'h1024 -> BIN=1024.
- BCDIN=16'h12A4 -> BIN=0, ERR=1. Following conversion of 16'h0042 -> BIN=42, ERR=0.
- START pulsed again at edges 5 and 20 of a conversion of 16'h0777 -> exactly one DONE, BIN=777; no second conversion starts.
- RST=0 asserted at edge 15 of a conversion of 16'h5000 -> BIN=0, DONE never pulses, BUSY=0 next cycle. A later conversion of 16'h5000 -> BIN=5000.
- START held high with BCDIN=16'h0001 then 16'h0010 -> DONE pulses 32 cycles apart; BIN=1 then BIN=10.
